// File: rtl/btc_dec_source_pkg.sv
// Shared types and helpers for the BTC decoder input stage.
// Address split matches the decoder controller: {row, col_word}.
package btc_dec_source_pkg;

    localparam int cPOS_W = 7;
    localparam int cCOL_W = 3;

    typedef enum logic [1:0] {
        cCODE_SPC  = 2'd0,
        cCODE_HAM  = 2'd1,
        cCODE_EHAM = 2'd2
    } btc_code_t;

    typedef struct packed {
        btc_code_t   code;
        logic [2:0]  log2n;
    } btc_code_mode_t;

    typedef struct packed {
        logic [cPOS_W-1:0] short_rows;
        logic [cPOS_W-1:0] short_cols;
    } btc_short_mode_t;

    typedef struct packed {
        logic [cPOS_W-1:0] nx;
        logic [cPOS_W-1:0] ny;
        logic [cPOS_W-1:0] srows;
        logic [cPOS_W-1:0] scols;
    } btc_geom_t;

    // Plain Hamming drops the parity bit of the extended code.
    function automatic logic [cPOS_W-1:0] get_code_bits(input btc_code_mode_t m);
        logic [2:0]        lg;
        logic [cPOS_W-1:0] n;
        lg = (m.log2n > 3'd6) ? 3'd6 : m.log2n;
        n  = cPOS_W'(1) << lg;
        return (m.code == cCODE_HAM) ? n - cPOS_W'(1) : n;
    endfunction

    function automatic int llr_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic logic [cPOS_W-1:0] col_word(
        input logic [cPOS_W-1:0] c,
        input int                lg
    );
        return c >> lg;
    endfunction

    function automatic logic [cPOS_W-1:0] col_bank(
        input logic [cPOS_W-1:0] c,
        input int                lg
    );
        return c & cPOS_W'((1 << lg) - 1);
    endfunction

endpackage

// File: rtl/btc_dec_source_cnt.sv
// Row/column scan position with wrap, shortened and last-position flags.
// Flags always describe the stored position under the latched geometry.
module btc_dec_source_cnt
    import btc_dec_source_pkg::*;
(
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              iload,
    input  logic              istep,
    input  btc_geom_t         icfg,
    input  logic [cPOS_W-1:0] inx,
    output logic [cPOS_W-1:0] ocol,
    output logic [cPOS_W-1:0] orow,
    output logic              oshort,
    output logic              olast
);

    logic [cPOS_W-1:0] c_q, c_d;
    logic [cPOS_W-1:0] r_q, r_d;
    logic [cPOS_W-1:0] base_c, base_r;

    // A load restarts at (0,0) and may step past it in the same cycle.
    always_comb begin
        base_c = iload ? '0 : c_q;
        base_r = iload ? '0 : r_q;
        c_d    = base_c;
        r_d    = base_r;
        if (istep) begin
            if (base_c == inx - cPOS_W'(1)) begin
                c_d = '0;
                r_d = base_r + cPOS_W'(1);
            end else begin
                c_d = base_c + cPOS_W'(1);
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            c_q <= '0;
            r_q <= '0;
        end else if (iclkena) begin
            c_q <= c_d;
            r_q <= r_d;
        end
    end

    assign ocol   = c_q;
    assign orow   = r_q;
    assign oshort = (r_q < icfg.srows) || (c_q < icfg.scols);
    assign olast  = (c_q == icfg.nx - cPOS_W'(1)) &&
                    (r_q == icfg.ny - cPOS_W'(1));

endmodule

// File: rtl/btc_dec_source.sv
// BTC decoder input stage: fills a 2-page banked LLR buffer row-major,
// inserting strong zero LLRs at shortened positions.
module btc_dec_source
    import btc_dec_source_pkg::*;
#(
    parameter int pADDR_W  = 8,
    parameter int pDEC_NUM = 8,
    parameter int pLLR_W   = 5
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic                iclkena,
    input  btc_code_mode_t      ixmode,
    input  btc_code_mode_t      iymode,
    input  btc_short_mode_t     ismode,
    input  logic                ival,
    input  logic                isop,
    input  logic                ieop,
    input  logic [pLLR_W-1:0]   iLLR,
    output logic                oready,
    input  logic                irbuf_rempty,
    output logic                obuf_full,
    output logic                owrite,
    output logic [pDEC_NUM-1:0] owsel,
    output logic [pADDR_W:0]    owaddr,
    output logic [pLLR_W-1:0]   owLLR,
    output logic                oerr
);

    localparam int cSEL_LG = $clog2(pDEC_NUM);
    localparam int cROW_W  = pADDR_W - cCOL_W;
    localparam logic [pLLR_W-1:0] cLLR_ZERO = pLLR_W'(llr_max(pLLR_W));

    localparam logic [1:0] cIDLE = 2'd0;
    localparam logic [1:0] cFILL = 2'd1;
    localparam logic [1:0] cDONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                page_q, page_d;
    logic [1:0]          used_q, used_d;
    logic                run_q;
    btc_geom_t           cfg_q, cfg_d, new_cfg;
    logic                held_vld_q, held_vld_d;
    logic [pLLR_W-1:0]   held_llr_q, held_llr_d;
    logic                held_eop_q, held_eop_d;
    logic                write_q, write_d;
    logic [pDEC_NUM-1:0] sel_q, sel_d;
    logic [pADDR_W:0]    addr_q, addr_d;
    logic [pLLR_W-1:0]   llr_q, llr_d;
    logic                err_q, err_d;

    logic [cPOS_W-1:0]   pos_c, pos_r, cnt_nx;
    logic                pos_short, pos_last;
    logic                acc, load, step, zero, take;
    logic                new_short0, new_last0, t_last, t_eop, do_wr;
    logic [pLLR_W-1:0]   t_llr;
    logic [cPOS_W-1:0]   wpos_c, wpos_r, wcw, wbank;

    assign new_cfg = '{
        nx:    get_code_bits(ixmode),
        ny:    get_code_bits(iymode),
        srows: ismode.short_rows,
        scols: ismode.short_cols
    };
    assign new_short0 = (ismode.short_rows != '0) ||
                        (ismode.short_cols != '0);
    assign new_last0  = (new_cfg.nx == cPOS_W'(1)) &&
                        (new_cfg.ny == cPOS_W'(1));

    assign oready = run_q && (
        (state_q == cIDLE && used_q != 2'd2) ||
        (state_q == cFILL && !pos_short && !held_vld_q));
    assign acc    = ival && oready;
    assign cnt_nx = load ? new_cfg.nx : cfg_q.nx;

    btc_dec_source_cnt u_cnt (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .iload   (load),
        .istep   (step),
        .icfg    (cfg_q),
        .inx     (cnt_nx),
        .ocol    (pos_c),
        .orow    (pos_r),
        .oshort  (pos_short),
        .olast   (pos_last)
    );

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        cfg_d      = cfg_q;
        held_vld_d = held_vld_q;
        held_llr_d = held_llr_q;
        held_eop_d = held_eop_q;
        write_d    = 1'b0;
        sel_d      = sel_q;
        addr_d     = addr_q;
        llr_d      = llr_q;
        err_d      = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        zero       = 1'b0;
        take       = 1'b0;
        t_llr      = iLLR;
        t_eop      = ieop;
        unique case (state_q)
            cIDLE: load = acc && isop;
            cFILL: begin
                if (acc && isop) begin
                    load  = 1'b1;
                    err_d = 1'b1;
                end else if (pos_short) begin
                    zero = 1'b1;
                end else if (held_vld_q) begin
                    take       = 1'b1;
                    t_llr      = held_llr_q;
                    t_eop      = held_eop_q;
                    held_vld_d = 1'b0;
                end else begin
                    take = acc;
                end
            end
            cDONE: begin
                page_d  = ~page_q;
                state_d = cIDLE;
            end
            default: state_d = cIDLE;
        endcase
        // A shortened first position parks the sop word until its slot.
        if (load) begin
            cfg_d      = new_cfg;
            state_d    = cFILL;
            held_vld_d = new_short0;
            held_llr_d = iLLR;
            held_eop_d = ieop;
            take       = !new_short0;
        end
        t_last = load ? new_last0 : pos_last;
        wpos_c = load ? '0 : pos_c;
        wpos_r = load ? '0 : pos_r;
        wcw    = col_word(wpos_c, cSEL_LG);
        wbank  = col_bank(wpos_c, cSEL_LG);
        do_wr  = zero || (take && (t_last || !t_eop));
        if (do_wr) begin
            write_d = 1'b1;
            sel_d   = pDEC_NUM'(1) << wbank;
            addr_d  = {page_q, wpos_r[cROW_W-1:0], wcw[cCOL_W-1:0]};
            llr_d   = zero ? cLLR_ZERO : t_llr;
        end
        if (zero) begin
            if (pos_last) state_d = cDONE;
            else          step    = 1'b1;
        end
        if (take) begin
            if (t_last) begin
                state_d = cDONE;
                err_d   = err_d | !t_eop;
            end else if (t_eop) begin
                state_d = cIDLE;
                err_d   = 1'b1;
            end else begin
                step = 1'b1;
            end
        end
    end

    always_comb begin
        used_d = used_q;
        if (state_q == cDONE)
            used_d = used_d + 2'd1;
        if (irbuf_rempty && used_q != 2'd0)
            used_d = used_d - 2'd1;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q    <= cIDLE;
            page_q     <= 1'b0;
            used_q     <= 2'd0;
            run_q      <= 1'b0;
            cfg_q      <= '0;
            held_vld_q <= 1'b0;
            held_llr_q <= '0;
            held_eop_q <= 1'b0;
            write_q    <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            llr_q      <= '0;
            err_q      <= 1'b0;
        end else if (iclkena) begin
            state_q    <= state_d;
            page_q     <= page_d;
            used_q     <= used_d;
            run_q      <= 1'b1;
            cfg_q      <= cfg_d;
            held_vld_q <= held_vld_d;
            held_llr_q <= held_llr_d;
            held_eop_q <= held_eop_d;
            write_q    <= write_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            llr_q      <= llr_d;
            err_q      <= err_d;
        end
    end

    assign obuf_full = (used_q != 2'd0);
    assign owrite    = write_q;
    assign owsel     = sel_q;
    assign owaddr    = addr_q;
    assign owLLR     = llr_q;
    assign oerr      = err_q;

endmodule

// File: doc/btc_dec_source.md
Name: btc_dec_source

Overview:
- Input stage of the BTC decoder: takes the serial soft-bit (LLR) stream of one code block and writes it into the 2-page, pDEC_NUM-bank decoder input buffer.
- Uses the same address layout the decoder controller reads: low bits = column word, high bits = row.
- Inserts strong "known zero" LLRs at shortened positions and drives the buffer-full flag (irbuf_full) to the decoder controller.
- Frees a page when the controller pulses its buffer-release strobe (obuf_rempty).

Parameters:
- pADDR_W, 8: per-page buffer address width; a page bit is appended above it.
- pDEC_NUM, 8: number of buffer banks/decoders; power of 2.
- pLLR_W, 5: soft-bit width, two's complement.

Ports:
- iclk  in  1  clock
- ireset  in  1  synchronous active-high reset
- iclkena  in  1  clock enable; all state frozen when low
- ixmode  in  btc_code_mode_t  row code mode; sampled on the accepted isop
- iymode  in  btc_code_mode_t  column code mode; sampled on the accepted isop
- ismode  in  btc_short_mode_t  shortening (short_rows, short_cols); sampled on the accepted isop
- ival  in  1  input LLR valid
- isop  in  1  first LLR of a block
- ieop  in  1  last LLR of a block
- iLLR  in  pLLR_W  input soft bit
- oready  out  1  upstream may present data
- irbuf_rempty  in  1  one-cycle page-release pulse from the controller
- obuf_full  out  1  at least one full page is ready (irbuf_full of the controller)
- owrite  out  1  buffer write strobe
- owsel  out  pDEC_NUM  one-hot bank select
- owaddr  out  pADDR_W+1  {page, row, col_word}
- owLLR  out  pLLR_W  write data
- oerr  out  1  one-cycle framing-error pulse

Behaviour:
- Reset values: oready=0, obuf_full=0, owrite=0, owsel=0, owaddr=0, owLLR=0, oerr=0. Write page = 0, used-page count = 0, FSM in IDLE.
- Geometry:
  - Nx = get_code_bits(ixmode), Ny = get_code_bits(iymode).
  - Column c: bank = c mod pDEC_NUM, col_word = c >> log2(pDEC_NUM).
  - Row r goes in the high address field.
- Shortened positions: rows r < short_rows, and columns c < short_cols of every row.
  - These positions are written internally with cLLR_ZERO (max positive value) and consume no input.
- Scan order: row-major, r = 0..Ny-1, c = 0..Nx-1.
- FSM states:
  - IDLE: oready=1 when used-page count < 2. Accepted ival&isop latches the modes and moves to FILL.
  - FILL: at each position, if shortened, write cLLR_ZERO with oready=0 (one cycle per position, stall). Otherwise oready=1, and ival writes iLLR.
    - A position counter tracks (c, r); c wraps at Nx-1 and increments r.
  - DONE (1 cycle): toggle write page, increment used count, return to IDLE.
  - The final position moves to DONE.
- An isop-accepted input position that is not shortened is written in the same step it is latched. Leading shortened positions are inserted first, with oready=0, before the first LLR is consumed.
  - The first LLR is held until consumed.
- Write latency: owrite/owsel/owaddr/owLLR are registered one cycle after acceptance/insertion.
- Framing errors (each raises oerr for 1 cycle):
  - ieop on a non-final position: abort the block; the page is not committed; go to IDLE.
  - isop during FILL: abort, then restart the block with this word.
  - No ieop on the final position: the block is committed anyway.
- Page accounting:
  - obuf_full = (used count != 0).
  - irbuf_rempty decrements the count; it is ignored when the count is 0.
  - DONE and irbuf_rempty in the same cycle leave the count unchanged.
  - With count = 2, oready=0 in IDLE until a release arrives.
- ireset mid-block: everything returns to reset values immediately; the partial page is discarded.
- iclkena low: no state change, outputs held, owrite held at its last value. The consumer qualifies writes with iclkena.

Decomposition:
- Package btc_dec_types additions: btc_short_mode_t fields short_rows/short_cols, constant cLLR_ZERO, address-split helpers shared with btc_dec_ctrl.
- Reuse get_code_bits from btc_parameters.
- One natural sub-module: btc_dec_source_cnt (row/column position counter with wrap, shortened-position flag and last-position flag).

Test Plan:
- Unshortened 8x8 SPC modes, pDEC_NUM=8:
  - 64 LLRs = 0..63 → writes to banks 0..7 at word 0, rows 0..7, page 0.
  - obuf_full rises 2 cycles after the last write.
  - No oerr.
- short_rows=1, short_cols=2 on 8x8:
  - 42 inputs are consumed.
  - 22 cLLR_ZERO writes: row 0 fully, plus columns 0-1 of rows 1-7.
  - oready is low exactly during those inserts.
- Two back-to-back blocks with no release:
  - Pages 0 and 1 filled; oready stays 0 in IDLE.
  - One irbuf_rempty pulse reopens input; a third block writes page 0.
- DONE coincident with irbuf_rempty: count is unchanged (1); obuf_full stays 1.
- ieop at position 10 of a 64-position block → oerr pulse, no page commit, obuf_full=0. Then isop mid-block → oerr, and the block restarts at r=0, c=0.
- ireset asserted at position 30 → all outputs 0 next cycle. A fresh block then fills page 0 correctly.
